// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALU op codes, major opcodes and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } issue_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of a decoded instruction into ALU op, operand B and legality.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_func3,
    input  logic [6:0]  i_func7,
    input  logic [31:0] i_rs2_val,
    input  logic [31:0] i_imm,
    output logic [3:0]  o_op,
    output logic [31:0] o_opb,
    output logic        o_legal
);

    logic w_f7_base;
    logic w_f7_alt;

    assign w_f7_base = (i_func7 == F7_BASE);
    assign w_f7_alt  = (i_func7 == F7_ALT);

    always_comb begin
        o_op    = ALU_ADD;
        o_opb   = 32'd0;
        o_legal = 1'b0;
        case (i_opcode)
            OP: begin
                o_op    = {i_func7[5], i_func3};
                o_opb   = i_rs2_val;
                // Only ADD/SUB and SRL/SRA have an alternate func7 encoding.
                o_legal = w_f7_base ||
                          (w_f7_alt && ((i_func3 == F3_ADD) || (i_func3 == F3_SR)));
            end
            OP_IMM: begin
                o_op    = {1'b0, i_func3};
                o_opb   = i_imm;
                o_legal = 1'b1;
                if (i_func3 == F3_SLL) begin
                    o_opb   = {27'd0, i_imm[4:0]};
                    o_legal = w_f7_base;
                end else if (i_func3 == F3_SR) begin
                    o_op    = {i_func7[5], F3_SR};
                    o_opb   = {27'd0, i_imm[4:0]};
                    o_legal = w_f7_base || w_f7_alt;
                end
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: accepts one decoded ALU instruction, drives the bit-serial ALU,
// waits (bounded) for completion and hands the result to writeback.
module alu_issue
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [6:0]   in_opcode,
    input  logic [2:0]   in_func3,
    input  logic [6:0]   in_func7,
    input  logic [4:0]   in_rd_idx,
    input  logic [31:0]  in_rs1_val,
    input  logic [31:0]  in_rs2_val,
    input  logic [31:0]  in_imm,
    output logic [31:0]  alu_rs1,
    output logic [31:0]  alu_rs2,
    output logic [3:0]   alu_op,
    output logic         alu_start,
    input  logic         alu_done,
    input  logic [31:0]  alu_rd,
    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [4:0]   wb_idx,
    output logic [31:0]  wb_data,
    output logic         wb_we,
    output logic         illegal,
    output logic         timeout,
    output issue_state_t dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    issue_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_alu_rs1;
    logic [31:0]      r_alu_rs2;
    logic [3:0]       r_alu_op;
    logic             r_alu_start;
    logic             r_wb_valid;
    logic [4:0]       r_wb_idx;
    logic [31:0]      r_wb_data;
    logic             r_wb_we;
    logic             r_illegal;
    logic             r_timeout;

    logic [3:0]       w_dec_op;
    logic [31:0]      w_dec_opb;
    logic             w_dec_legal;

    alu_op_decode u_decode (
        .i_opcode  (in_opcode),
        .i_func3   (in_func3),
        .i_func7   (in_func7),
        .i_rs2_val (in_rs2_val),
        .i_imm     (in_imm),
        .o_op      (w_dec_op),
        .o_opb     (w_dec_opb),
        .o_legal   (w_dec_legal)
    );

    // Handshakes: in_valid/in_ready and wb_valid/wb_ready each transfer on a rising
    // edge where both are high; a raised valid holds its payload until that edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_alu_rs1   <= 32'd0;
            r_alu_rs2   <= 32'd0;
            r_alu_op    <= 4'd0;
            r_alu_start <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_idx    <= 5'd0;
            r_wb_data   <= 32'd0;
            r_wb_we     <= 1'b0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_dec_legal) begin
                            r_alu_op    <= w_dec_op;
                            r_alu_rs1   <= in_rs1_val;
                            r_alu_rs2   <= w_dec_opb;
                            r_wb_idx    <= in_rd_idx;
                            r_wb_we     <= (in_rd_idx != 5'd0);
                            r_alu_start <= 1'b1;
                            r_state     <= ISSUE;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Operands stay untouched here: the serial ALU keeps sampling them.
                    if (alu_done) begin
                        r_wb_data  <= alu_rd;
                        r_wb_valid <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= WB;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign alu_rs1   = r_alu_rs1;
    assign alu_rs2   = r_alu_rs2;
    assign alu_op    = r_alu_op;
    assign alu_start = r_alu_start;
    assign wb_valid  = r_wb_valid;
    assign wb_idx    = r_wb_idx;
    assign wb_data   = r_wb_data;
    assign wb_we     = r_wb_we;
    assign illegal   = r_illegal;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed spec scenarios plus randomized instruction stream
// checked through issue/writeback expectation queues.
module tb_alu_issue;
    import alu_pkg::*;

    localparam int TO    = 80;
    localparam int NRAND = 150;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [6:0]   in_opcode;
    logic [2:0]   in_func3;
    logic [6:0]   in_func7;
    logic [4:0]   in_rd_idx;
    logic [31:0]  in_rs1_val;
    logic [31:0]  in_rs2_val;
    logic [31:0]  in_imm;
    logic [31:0]  alu_rs1;
    logic [31:0]  alu_rs2;
    logic [3:0]   alu_op;
    logic         alu_start;
    logic         alu_done;
    logic [31:0]  alu_rd;
    logic         wb_valid;
    logic         wb_ready;
    logic [4:0]   wb_idx;
    logic [31:0]  wb_data;
    logic         wb_we;
    logic         illegal;
    logic         timeout;
    issue_state_t dbg_state;

    alu_issue #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_func3   (in_func3),
        .in_func7   (in_func7),
        .in_rd_idx  (in_rd_idx),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .in_imm     (in_imm),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_rd     (alu_rd),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .wb_we      (wb_we),
        .illegal    (illegal),
        .timeout    (timeout),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [67:0] iss_q[$];   // {alu_op, alu_rs1, alu_rs2}
    logic [37:0] wb_q[$];    // {wb_we, wb_idx, wb_data}
    int exp_illegal = 0;
    int got_illegal = 0;
    int exp_start   = 0;
    int got_start   = 0;
    int got_timeout = 0;
    int wb_mode     = 0;     // 0 always ready, 1 random, 2 held low
    bit stub_hold   = 1'b0;
    bit late_done_req = 1'b0;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        bit          legal;
        logic [3:0]  op;
        logic [31:0] opb;
        logic [31:0] res;
    } instr_t;

    // Mnemonic table: 0..9 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND,
    // 10..15 ADDI SLTI SLTIU XORI ORI ANDI, 16..18 SLLI SRLI SRAI.
    logic [2:0] mn_f3 [19] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7,
                               3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5};
    logic [6:0] mn_f7 [19] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00,
                               7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
    logic [3:0] mn_op [19] = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7,
                               4'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd1, 4'd5, 4'd13};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of each ALU op, used for the ALU stub and expectations.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd8:  return a - b;
            4'd1:  return a << b[4:0];
            4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a >> b[4:0];
            4'd13: return $unsigned($signed(a) >>> b[4:0]);
            4'd6:  return a | b;
            4'd7:  return a & b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic instr_t make_legal(input int k, input logic [4:0] rd, input logic [31:0] rs1,
                                          input logic [31:0] rs2, input logic [31:0] rnd);
        instr_t t;
        t.legal = 1'b1;
        t.rd    = rd;
        t.rs1   = rs1;
        t.rs2   = rs2;
        t.f3    = mn_f3[k];
        t.op    = mn_op[k];
        if (k < 10) begin
            t.opc = 7'b0110011;
            t.f7  = mn_f7[k];
            t.imm = rnd;
            t.opb = rs2;
        end else if (k >= 16) begin
            t.opc = 7'b0010011;
            t.f7  = mn_f7[k];
            t.imm = rnd;
            t.opb = {27'd0, rnd[4:0]};
        end else begin
            t.opc = 7'b0010011;
            t.imm = {{20{rnd[11]}}, rnd[11:0]};
            t.f7  = rnd[11:5];
            t.opb = t.imm;
        end
        t.res = alu_ref(t.op, rs1, t.opb);
        return t;
    endfunction

    function automatic instr_t make_illegal(input int variant);
        instr_t t;
        t.legal = 1'b0;
        t.rd  = 5'($urandom);
        t.rs1 = $urandom;
        t.rs2 = $urandom;
        t.imm = $urandom;
        t.op  = 4'd0;
        t.opb = 32'd0;
        t.res = 32'd0;
        t.f3  = 3'($urandom);
        t.f7  = 7'($urandom);
        case (variant)
            0: begin
                do t.opc = 7'($urandom); while (t.opc == 7'b0110011 || t.opc == 7'b0010011);
            end
            1: begin
                t.opc = 7'b0110011;
                do t.f7 = 7'($urandom); while (t.f7 == 7'h00 || t.f7 == 7'h20);
            end
            2: begin
                t.opc = 7'b0110011;
                t.f7  = 7'h20;
                do t.f3 = 3'($urandom); while (t.f3 == 3'd0 || t.f3 == 3'd5);
            end
            3: begin
                t.opc = 7'b0010011;
                t.f3  = 3'd1;
                do t.f7 = 7'($urandom); while (t.f7 == 7'h00);
            end
            default: begin
                t.opc = 7'b0010011;
                t.f3  = 3'd5;
                do t.f7 = 7'($urandom); while (t.f7 == 7'h00 || t.f7 == 7'h20);
            end
        endcase
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input instr_t t, input bit expect_wb);
        int n;
        @(negedge clk);
        in_opcode  = t.opc;
        in_func3   = t.f3;
        in_func7   = t.f7;
        in_rd_idx  = t.rd;
        in_rs1_val = t.rs1;
        in_rs2_val = t.rs2;
        in_imm     = t.imm;
        in_valid   = 1'b1;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (t.legal) begin
            iss_q.push_back({t.op, t.rs1, t.opb});
            exp_start++;
            if (expect_wb) wb_q.push_back({(t.rd != 5'd0), t.rd, t.res});
        end else begin
            exp_illegal++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((!in_ready || wb_q.size() != 0 || iss_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < 3000), 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_alu_start"}, 64'(alu_start), 64'd0);
        chk({tag, "_wb_valid"},  64'(wb_valid),  64'd0);
        chk({tag, "_wb_we"},     64'(wb_we),     64'd0);
        chk({tag, "_illegal"},   64'(illegal),   64'd0);
        chk({tag, "_timeout"},   64'(timeout),   64'd0);
        chk({tag, "_alu_op"},    64'(alu_op),    64'd0);
        chk({tag, "_alu_rs1"},   64'(alu_rs1),   64'd0);
        chk({tag, "_alu_rs2"},   64'(alu_rs2),   64'd0);
        chk({tag, "_wb_idx"},    64'(wb_idx),    64'd0);
        chk({tag, "_wb_data"},   64'(wb_data),   64'd0);
    endtask

    // ---------------- wb_ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (wb_mode)
            0:       wb_ready = 1'b1;
            1:       wb_ready = ($urandom_range(0, 2) != 0);
            default: wb_ready = 1'b0;
        endcase
    end

    // ---------------- ALU stub ----------------
    initial begin : alu_stub
        logic [3:0]  s_op;
        logic [31:0] s_a;
        logic [31:0] s_b;
        int          lat;
        alu_done = 1'b0;
        alu_rd   = 32'd0;
        forever begin
            @(negedge clk);
            if (late_done_req) begin
                alu_done = 1'b1;
                alu_rd   = 32'h1234_5678;
                @(negedge clk);
                alu_done = 1'b0;
                late_done_req = 1'b0;
            end else if (rst && alu_start && !stub_hold) begin
                s_op = alu_op;
                s_a  = alu_rs1;
                s_b  = alu_rs2;
                lat  = $urandom_range(1, 6);
                repeat (lat) begin
                    @(negedge clk);
                    chk("operand_hold", 64'({alu_op, alu_rs1, alu_rs2} === {s_op, s_a, s_b}), 64'd1);
                end
                alu_done = 1'b1;
                alu_rd   = alu_ref(s_op, s_a, s_b);
                @(negedge clk);
                alu_done = 1'b0;
                alu_rd   = $urandom;
                chk("wb_valid_latency", 64'(wb_valid), 64'd1);
            end
        end
    end

    // ---------------- monitor ----------------
    logic        wb_hold = 1'b0;
    logic [37:0] wb_held;

    always @(negedge clk) begin : monitor
        logic [67:0] ie;
        logic [37:0] we;
        if (rst) begin
            if (alu_start) begin
                got_start++;
                if (iss_q.size() == 0) begin
                    chk("unexpected_alu_start", 64'd1, 64'd0);
                end else begin
                    ie = iss_q.pop_front();
                    chk("alu_op",  64'(alu_op),  64'(ie[67:64]));
                    chk("alu_rs1", 64'(alu_rs1), 64'(ie[63:32]));
                    chk("alu_rs2", 64'(alu_rs2), 64'(ie[31:0]));
                end
            end
            if (wb_valid) begin
                if (wb_hold) chk("wb_stable", 64'({wb_we, wb_idx, wb_data}), 64'(wb_held));
                if (wb_ready) begin
                    wb_hold = 1'b0;
                    if (wb_q.size() == 0) begin
                        chk("unexpected_wb", 64'd1, 64'd0);
                    end else begin
                        we = wb_q.pop_front();
                        chk("wb_we",   64'(wb_we),   64'(we[37]));
                        chk("wb_idx",  64'(wb_idx),  64'(we[36:32]));
                        chk("wb_data", 64'(wb_data), 64'(we[31:0]));
                    end
                end else begin
                    wb_hold = 1'b1;
                    wb_held = {wb_we, wb_idx, wb_data};
                end
            end else begin
                wb_hold = 1'b0;
            end
            if (illegal) got_illegal++;
            if (timeout) got_timeout++;
        end else begin
            wb_hold = 1'b0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        instr_t t;
        int     n;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_opcode  = 7'd0;
        in_func3   = 3'd0;
        in_func7   = 7'd0;
        in_rd_idx  = 5'd0;
        in_rs1_val = 32'd0;
        in_rs2_val = 32'd0;
        in_imm     = 32'd0;
        wb_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_release");
        chk("rst_state", 64'(dbg_state), 64'(IDLE));

        // ADD rs1=5 rs2=7 rd=3
        t = make_legal(0, 5'd3, 32'd5, 32'd7, 32'd0);
        t.op = 4'b0000; t.res = 32'd12;
        send(t, 1'b1);
        chk("add_start_latency", 64'(alu_start), 64'd1);
        chk("add_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("add_start_one_cycle", 64'(alu_start), 64'd0);
        wait_idle("add_done");

        // SUB rs1=3 rs2=5
        t = make_legal(1, 5'd9, 32'd3, 32'd5, 32'd0);
        t.op = 4'b1000; t.res = 32'hFFFF_FFFE;
        send(t, 1'b1);
        wait_idle("sub_done");

        // SRAI 0x80000000 by 4
        t = make_legal(18, 5'd17, 32'h8000_0000, 32'd0, 32'd4);
        t.op = 4'b1101; t.opb = 32'h0000_0004; t.res = 32'hF800_0000;
        send(t, 1'b1);
        wait_idle("srai_done");

        // ADDI to x0: writeback presented but not enabled
        t = make_legal(10, 5'd0, 32'd100, 32'd0, 32'h0000_0FFF);
        send(t, 1'b1);
        wait_idle("addi_x0_done");

        // R-type with func7 0000001 is illegal
        t = make_illegal(1);
        t.f7 = 7'b0000001;
        t.f3 = 3'd0;
        send(t, 1'b0);
        chk("illegal_pulse", 64'(illegal), 64'd1);
        chk("illegal_no_start", 64'(alu_start), 64'd0);
        chk("illegal_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("illegal_one_cycle", 64'(illegal), 64'd0);

        // writeback back-pressure for 10 cycles
        wb_mode = 2;
        t = make_legal(8, 5'd5, $urandom, $urandom, 32'd0);
        send(t, 1'b1);
        n = 0;
        while (!wb_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wb_valid_seen", 64'(wb_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_wb_valid_held", 64'(wb_valid), 64'd1);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        wb_mode = 0;
        wait_idle("bp_done");

        // ALU never answers: timeout after TO WAIT cycles
        stub_hold = 1'b1;
        t = make_legal(0, 5'd4, 32'd1, 32'd2, 32'd0);
        send(t, 1'b0);
        n = 0;
        while (!timeout && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'(TO + 1));
        chk("timeout_in_ready", 64'(in_ready), 64'd1);
        chk("timeout_no_wb", 64'(wb_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("timeout_one_cycle", 64'(timeout), 64'd0);

        // reset in the middle of WAIT, then a stale alu_done
        t = make_legal(4, 5'd6, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0);
        send(t, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("rstwait_in_wait", 64'(dbg_state), 64'(WAIT));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("rstwait");
        @(negedge clk);
        rst = 1'b1;
        stub_hold = 1'b0;
        late_done_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("late_done_no_wb", 64'(wb_valid), 64'd0);
        chk("late_done_idle", 64'(dbg_state), 64'(IDLE));
        chk("late_done_wb_data", 64'(wb_data), 64'd0);

        // randomized stream with random writeback back-pressure
        wb_mode = 1;
        for (int i = 0; i < NRAND; i++) begin
            if ($urandom_range(0, 9) == 0)
                t = make_illegal($urandom_range(0, 4));
            else
                t = make_legal($urandom_range(0, 18), 5'($urandom), $urandom, $urandom, $urandom);
            send(t, 1'b1);
        end
        wait_idle("random_drain");
        wb_mode = 0;

        chk("illegal_count", 64'(got_illegal), 64'(exp_illegal));
        chk("start_count", 64'(got_start), 64'(exp_start));
        chk("timeout_count", 64'(got_timeout), 64'd1);
        chk("iss_q_empty", 64'(iss_q.size()), 64'd0);
        chk("wb_q_empty", 64'(wb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 80: maximum cycles to wait for alu_done before aborting.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-004 in_valid in 1 / in_ready out 1: decode-to-issue handshake; transfer when both high on a rising edge.
REQ-005 in_opcode in 7, in_func3 in 3, in_func7 in 7, in_rd_idx in 5: decoded instruction fields.
REQ-006 in_rs1_val in 32, in_rs2_val in 32, in_imm in 32 (sign-extended): operand values.
REQ-007 alu_rs1 out 32, alu_rs2 out 32, alu_op out 4, alu_start out 1: drive the bit-serial ALU.
REQ-008 alu_done in 1, alu_rd in 32: ALU completion pulse and result.
REQ-009 wb_valid out 1, wb_ready in 1, wb_idx out 5, wb_data out 32, wb_we out 1: writeback handshake.
REQ-010 illegal out 1: one-cycle pulse on an unsupported instruction; timeout out 1: one-cycle pulse on ALU abort.

Function
REQ-011 States SHALL be IDLE, ISSUE, WAIT, WB.
REQ-012 in_ready SHALL be high only in IDLE.
REQ-013 On transfer, the block SHALL register the op code, alu_rs1, alu_rs2, wb_idx and wb_we, then move to ISSUE.
- Exception: an illegal instruction pulses illegal on the next cycle and stays in IDLE.
REQ-014 Decoding for opcode 0110011 (R-type): alu_op = {func7[5], func3}.
- func7 SHALL be 0000000, or 0100000 only with func3 000 or 101.
- alu_rs2 = in_rs2_val.
REQ-015 Decoding for opcode 0010011 (I-type): alu_op = {0, func3}, except func3 101, which uses {func7[5], 101}.
- func3 001 requires func7 0000000; func3 101 requires func7 0000000 or 0100000.
- Shifts: alu_rs2 = {27'b0, in_imm[4:0]}; others: alu_rs2 = in_imm.
REQ-016 Any other opcode SHALL be illegal.
REQ-017 wb_we SHALL be 0 when in_rd_idx == 0, otherwise 1.
REQ-018 ISSUE SHALL assert alu_start for exactly one cycle, then move to WAIT.
REQ-019 alu_rs1, alu_rs2 and alu_op SHALL stay constant from ISSUE until leaving WAIT, since the ALU samples operands serially.
REQ-020 In WAIT, on the edge alu_done is sampled high, the block SHALL capture alu_rd into wb_data and move to WB.
- wb_valid SHALL rise the following cycle.
REQ-021 A WAIT cycle counter SHALL, on reaching TIMEOUT_CYCLES without alu_done, pulse timeout and return to IDLE with no writeback.
REQ-022 In WB, wb_valid, wb_idx, wb_data and wb_we SHALL hold steady until wb_ready is sampled high; the block then returns to IDLE.
REQ-023 Back-to-back throughput: next in_ready no earlier than the cycle after the WB handshake.
REQ-024 alu_done seen outside WAIT SHALL be ignored.
REQ-025 Latency: transfer at edge T gives ISSUE in cycle T+1 and alu_start high in cycle T+1; wb_valid rises in cycle D+1, where D is the edge sampling alu_done.

Reset
REQ-026 While rst is low at a rising edge, the block SHALL enter IDLE, including mid-WAIT or mid-WB, discarding the in-flight instruction.
REQ-027 Reset values: in_ready 1 (after reset), alu_start 0, wb_valid 0, wb_we 0, illegal 0, timeout 0, alu_op 0, alu_rs1 0, alu_rs2 0, wb_idx 0, wb_data 0, counter 0.

Structure
REQ-028 Package alu_pkg SHALL hold:
- the 4-bit ALU op encodings (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111);
- opcode constants OP 0110011 and OP_IMM 0010011;
- the issue_state_t enum.
REQ-029 Combinational decode (op, operand-b select, legality) SHALL be a sub-module alu_op_decode; the FSM, counter and registers stay in alu_issue.

Verification
REQ-030 R-type ADD, rs1=5, rs2=7, rd=3, wb_ready=1 -> one alu_start pulse, alu_op 0000, then wb_valid with wb_idx 3, wb_data 12, wb_we 1.
REQ-031 R-type SUB (func7 0100000), rs1=3, rs2=5 -> alu_op 1000, wb_data 0xFFFFFFFE.
REQ-032 I-type SRAI, func7 0100000, rs1 0x80000000, imm 4 -> alu_op 1101, alu_rs2 0x00000004, wb_data 0xF8000000.
REQ-033 ADDI with rd=0 -> wb_valid asserted with wb_we 0; R-type func7 0000001 -> illegal pulse, no alu_start, in_ready stays high.
REQ-034 wb_ready held low 10 cycles -> wb outputs stable and in_ready low throughout; alu_done withheld -> timeout pulse after 80 WAIT cycles, then IDLE.
REQ-035 rst low during WAIT -> next cycle all outputs at reset values; a late alu_done is ignored.
